// File: rtl/wb_sram_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-16-bit async SRAM controller:
// FSM state encoding and halfword-select helpers.
package wb_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  // Half 0 carries word bits 31:16 (even halfword address), half 1 bits 15:0.
  localparam logic HALF_HI = 1'b0;
  localparam logic HALF_LO = 1'b1;

  // Halfword of a 32-bit word selected by the half index.
  function automatic logic [15:0] half_data(input logic [31:0] w, input logic h);
    return h ? w[15:0] : w[31:16];
  endfunction

  // Two byte-lane selects {upper, lower} belonging to a half.
  function automatic logic [1:0] half_sel(input logic [3:0] s, input logic h);
    return h ? s[1:0] : s[3:2];
  endfunction

  // A read always touches both halves; a write only halves with a lane set.
  function automatic logic half_needed(input logic we, input logic [3:0] s, input logic h);
    return !we || (half_sel(s, h) != 2'b00);
  endfunction

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving a 16-bit asynchronous SRAM. Each 32-bit
// access becomes up to two halfword cycles (SETUP, STROBE of W+1 cycles,
// HOLD for writes). All Wishbone and SRAM outputs are registered and
// change on the same edge as the FSM state.
//
// Handshake: a request is wb_cyc_i & wb_stb_i sampled in IDLE; the slave
// answers with exactly one wb_ack_o cycle (only if wb_cyc_i is still high
// when the last SRAM cycle finishes), then returns to IDLE, so a held
// strobe after the ack is taken as a new request.
module wb_sram_ctrl
  import wb_sram_ctrl_pkg::*;
#(
  parameter int adr_width   = 19,
  parameter int wait_cycles = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic [2:0]           wb_cti_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] sram_adr,
  output logic [15:0]          sram_d_o,
  input  logic [15:0]          sram_d_i,
  output logic                 sram_d_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  output logic [2:0]           dbg_state_o
);

  localparam int CW = (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(wait_cycles);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Burst type is ignored and address bits outside the SRAM are decoded upstream.
  logic unused_ok;
  assign unused_ok = ^{wb_cti_i, wb_adr_i[31:adr_width+1], wb_adr_i[1:0]};

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   half_q, half_d;
  logic [adr_width-2:0]   adr_q, adr_d;
  logic [31:0]            dat_q, dat_d;
  logic [3:0]             sel_q, sel_d;
  logic                   we_q, we_d;
  logic [31:0]            rdat_q, rdat_d;

  logic                   ack_q, ack_d;
  logic [31:0]            dat_o_q, dat_o_d;
  logic [adr_width-1:0]   sram_adr_q, sram_adr_d;
  logic [15:0]            d_o_q, d_o_d;
  logic                   d_oe_q, d_oe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   ub_n_q, ub_n_d;
  logic                   lb_n_q, lb_n_d;

  logic                   req;
  logic                   half_done;

  assign req = wb_cyc_i & wb_stb_i;

  // Next state, wait counter, request latch and read-data assembly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    dat_o_d   = dat_o_q;
    half_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d  = wb_adr_i[adr_width:2];
          dat_d  = wb_dat_i;
          sel_d  = wb_sel_i;
          we_d   = wb_we_i;
          rdat_d = '0;
          if (wb_we_i && (wb_sel_i == 4'b0000)) begin
            // No byte enabled: acknowledge without touching the SRAM.
            state_d = ST_ACK;
            ack_d   = wb_cyc_i;
          end else begin
            state_d = ST_SETUP;
            half_d  = half_needed(wb_we_i, wb_sel_i, HALF_HI) ? HALF_HI : HALF_LO;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = CNT_LOAD;
      end
      ST_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (we_q) begin
          state_d = ST_HOLD;
        end else begin
          // Last strobe cycle of a read: data has had the full access time.
          rdat_d    = half_q ? {rdat_q[31:16], sram_d_i} : {sram_d_i, rdat_q[15:0]};
          half_done = 1'b1;
        end
      end
      ST_HOLD: begin
        half_done = 1'b1;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (half_done) begin
      if ((half_q == HALF_HI) && half_needed(we_q, sel_q, HALF_LO)) begin
        state_d = ST_SETUP;
        half_d  = HALF_LO;
      end else begin
        state_d = ST_ACK;
        ack_d   = wb_cyc_i;
        if (!we_q) begin
          dat_o_d = rdat_d;
        end
      end
    end
  end

  // SRAM pin values for the state being entered, so pins and state move together.
  always_comb begin
    sram_adr_d = sram_adr_q;
    d_o_d      = d_o_q;
    d_oe_d     = 1'b0;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    ub_n_d     = 1'b1;
    lb_n_d     = 1'b1;

    if ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD)) begin
      sram_adr_d = {adr_d, half_d};
      d_o_d      = half_data(dat_d, half_d);
      d_oe_d     = we_d;
      ce_n_d     = 1'b0;
      {ub_n_d, lb_n_d} = we_d ? ~half_sel(sel_d, half_d) : 2'b00;
      if (state_d == ST_STROBE) begin
        if (we_d) begin
          we_n_d = 1'b0;
        end else begin
          oe_n_d = 1'b0;
        end
      end
    end
  end

  // State, latched request and registered outputs; reset drops any access.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      half_q     <= HALF_HI;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      rdat_q     <= '0;
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
      sram_adr_q <= '0;
      d_o_q      <= '0;
      d_oe_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      rdat_q     <= rdat_d;
      ack_q      <= ack_d;
      dat_o_q    <= dat_o_d;
      sram_adr_q <= sram_adr_d;
      d_o_q      <= d_o_d;
      d_oe_q     <= d_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_o_q;
  assign sram_adr    = sram_adr_q;
  assign sram_d_o    = d_o_q;
  assign sram_d_oe   = d_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;
  assign dbg_state_o = state_q;

endmodule
